fbf_add_arbiter: RTL and testbench

Round-robin scheduler that shares one `fbf_adder` (SIZE×SIZE matrix of 32-bit floats) between NREQ requesters. It grants one request at a time and latches that requester's operand matrices. It then sequences the adder's strobe/ready/ack handshake and returns the sum matrix to the granted requester. A watchdog turns a hung adder into an error response instead of a deadlock.

---
 rtl/fbf_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/fbf_add_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fbf_add_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fbf_ctrl_pkg.sv
// Shared types and helpers for the fbf adder control blocks.
// No logic of its own; state encoding and matrix width helper only.
// Not applicable (no datapath).
package fbf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int FP_W = 32;

    // Bit width of a SIZE x SIZE matrix of single-precision floats.
    function automatic int mat_w(input int size);
        return FP_W * size * size;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after last_grant+1 (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter
    import fbf_ctrl_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the requesters starting just after the previous winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_grant) + i) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fbf_add_arbiter.sv
// Shares one external fbf_adder between NREQ requesters, round-robin, one job at a time.
// Latency: req seen N -> req_ack N+1; adder ready M -> resp_ready M+1; timeout at N+2+TIMEOUT.
// Backpressure: new grants wait for resp_ack of the current one and for any stale adder result to drain.
module fbf_add_arbiter
    import fbf_ctrl_pkg::*;
#(
    parameter  int SIZE    = 4,
    parameter  int NREQ    = 2,
    parameter  int TIMEOUT = 64,
    localparam int W       = mat_w(SIZE),
    localparam int IW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_stb,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   resp_ready,
    output logic              resp_err,
    output logic [W-1:0]      resp_result,
    input  logic [NREQ-1:0]   resp_ack,
    output logic              add_a_stb,
    output logic              add_b_stb,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic              add_result_ready,
    input  logic [W-1:0]      add_result,
    output logic              add_result_ack
);

    // Watchdog only has to reach TIMEOUT-1 before WAIT is abandoned.
    localparam int TW = $clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [IW-1:0]   g_q, last_grant_q, arb_idx;
    logic [NREQ-1:0] arb_grant, g_onehot;
    logic [W-1:0]    a_q, b_q, result_q, sel_a, sel_b;
    logic            err_q, stale_q;
    logic [TW-1:0]   wdog_q;
    logic            do_issue, do_capture, do_timeout, do_drain, do_release;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req_stb),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    assign g_onehot    = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
    assign add_a       = a_q;
    assign add_b       = b_q;
    assign resp_result = result_q;
    assign resp_err    = err_q;

    // Select the winning requester's operand slices.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and datapath enables.
    always_comb begin
        state_d        = state_q;
        req_ack        = '0;
        resp_ready     = '0;
        add_a_stb      = 1'b0;
        add_b_stb      = 1'b0;
        add_result_ack = 1'b0;
        do_issue       = 1'b0;
        do_capture     = 1'b0;
        do_timeout     = 1'b0;
        do_drain       = 1'b0;
        do_release     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stale_q && (|arb_grant)) begin
                    do_issue = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                req_ack   = g_onehot;
                add_a_stb = 1'b1;
                add_b_stb = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (add_result_ready) begin
                    add_result_ack = 1'b1;
                    do_capture     = 1'b1;
                    state_d        = ST_RESP;
                end else if (wdog_q == TW'(TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_ready = g_onehot;
                if (resp_ack[g_q]) begin
                    do_release = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A result that arrives after the watchdog gave up is swallowed here.
        if (state_q != ST_WAIT && stale_q && add_result_ready) begin
            add_result_ack = 1'b1;
            do_drain       = 1'b1;
        end
    end

    // Grant bookkeeping, operand/result registers, watchdog and stale flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_q          <= '0;
            last_grant_q <= IW'(NREQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            stale_q      <= 1'b0;
            wdog_q       <= '0;
        end else begin
            if (do_issue) begin
                g_q <= arb_idx;
                a_q <= sel_a;
                b_q <= sel_b;
            end
            if (state_q == ST_ISSUE) begin
                wdog_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wdog_q <= wdog_q + TW'(1);
            end
            if (do_capture) begin
                result_q <= add_result;
            end
            if (do_timeout) begin
                result_q <= '0;
                err_q    <= 1'b1;
                stale_q  <= 1'b1;
            end
            if (do_drain) begin
                stale_q <= 1'b0;
            end
            if (do_release) begin
                last_grant_q <= g_q;
                err_q        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fbf_add_arbiter.sv
// Directed bench for fbf_add_arbiter with the adder played by hand-timed stimulus.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Adder latency and requester ack timing are chosen per scenario.
module tb_fbf_add_arbiter;
    localparam int SIZE    = 4;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;
    localparam int NE      = SIZE * SIZE;
    localparam int W       = 32 * NE;

    localparam logic [W-1:0] F_0P5 = {NE{32'h3F00_0000}};
    localparam logic [W-1:0] F_1   = {NE{32'h3F80_0000}};
    localparam logic [W-1:0] F_2   = {NE{32'h4000_0000}};
    localparam logic [W-1:0] F_3   = {NE{32'h4040_0000}};
    localparam logic [W-1:0] F_4   = {NE{32'h4080_0000}};
    localparam logic [W-1:0] F_4P5 = {NE{32'h4090_0000}};
    localparam logic [W-1:0] F_7   = {NE{32'h40E0_0000}};
    localparam logic [W-1:0] ZERO  = '0;

    logic              clk;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_stb = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   resp_ready;
    logic              resp_err;
    logic [W-1:0]      resp_result;
    logic [NREQ-1:0]   resp_ack = '0;
    logic              add_a_stb, add_b_stb;
    logic [W-1:0]      add_a, add_b;
    logic              add_result_ready = 1'b0;
    logic [W-1:0]      add_result = '0;
    logic              add_result_ack;

    int n_tests = 0;
    int n_fail  = 0;

    fbf_add_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_stb          (req_stb),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ack          (req_ack),
        .resp_ready       (resp_ready),
        .resp_err         (resp_err),
        .resp_result      (resp_result),
        .resp_ack         (resp_ack),
        .add_a_stb        (add_a_stb),
        .add_b_stb        (add_b_stb),
        .add_a            (add_a),
        .add_b            (add_b),
        .add_result_ready (add_result_ready),
        .add_result       (add_result),
        .add_result_ack   (add_result_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick(); tick(); #1;
        n_tests++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL rst_req_ack: got %b exp 00", req_ack); end
        n_tests++; if (resp_ready !== 2'b00) begin n_fail++; $display("FAIL rst_resp_ready: got %b exp 00", resp_ready); end
        n_tests++; if ({resp_err, add_a_stb, add_b_stb, add_result_ack} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b exp 0000", {resp_err, add_a_stb, add_b_stb, add_result_ack}); end
        n_tests++; if (add_a !== ZERO || add_b !== ZERO) begin n_fail++; $display("FAIL rst_operands: got %h / %h exp 0", add_a, add_b); end
        n_tests++; if (resp_result !== ZERO) begin n_fail++; $display("FAIL rst_result: got %h exp 0", resp_result); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_a = {F_4, F_1};
        req_b = {F_0P5, F_2};
        req_stb = 2'b01; #1;
        n_tests++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_early: got %b exp 00", req_ack); end
        tick(); #1;
        n_tests++; if (req_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b exp 01", req_ack); end
        n_tests++; if ({add_a_stb, add_b_stb} !== 2'b11) begin n_fail++; $display("FAIL single_stb: got %b exp 11", {add_a_stb, add_b_stb}); end
        n_tests++; if (add_a !== F_1 || add_b !== F_2) begin n_fail++; $display("FAIL single_operands: got %h / %h exp ones/twos", add_a, add_b); end
        req_stb = 2'b00;
        tick(); #1;
        n_tests++; if (req_ack !== 2'b00 || resp_ready !== 2'b00) begin n_fail++; $display("FAIL single_wait: got ack %b ready %b exp 00 00", req_ack, resp_ready); end
        tick();
        tick();
        add_result_ready = 1'b1; add_result = F_3; #1;
        n_tests++; if (add_result_ack !== 1'b1) begin n_fail++; $display("FAIL single_add_ack: got %b exp 1", add_result_ack); end
        tick();
        add_result_ready = 1'b0; add_result = ZERO; #1;
        n_tests++; if (resp_ready !== 2'b01 || resp_err !== 1'b0) begin n_fail++; $display("FAIL single_resp: got ready %b err %b exp 01 0", resp_ready, resp_err); end
        n_tests++; if (resp_result !== F_3) begin n_fail++; $display("FAIL single_result: got %h exp threes", resp_result); end
        n_tests++; if (add_result_ack !== 1'b0) begin n_fail++; $display("FAIL single_add_ack_drop: got %b exp 0", add_result_ack); end
        resp_ack = 2'b01;
        tick();
        resp_ack = 2'b00; #1;
        n_tests++; if (resp_ready !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b exp 00", resp_ready); end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] oh;
        logic [W-1:0]    ea, eb, es;
        reset = 1'b0; #1; reset = 1'b1;
        tick();
        req_a = {F_4, F_1};
        req_b = {F_0P5, F_2};
        req_stb = 2'b11;
        for (int t = 0; t < 4; t++) begin
            oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            ea = (t % 2 == 0) ? F_1 : F_4;
            eb = (t % 2 == 0) ? F_2 : F_0P5;
            es = (t % 2 == 0) ? F_3 : F_4P5;
            #1;
            n_tests++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b exp 00", t, req_ack); end
            tick(); #1;
            n_tests++; if (req_ack !== oh) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b exp %b", t, req_ack, oh); end
            n_tests++; if (add_a !== ea || add_b !== eb) begin n_fail++; $display("FAIL b2b_operands[%0d]: got %h / %h", t, add_a, add_b); end
            req_stb = req_stb & ~oh;
            tick();
            add_result_ready = 1'b1; add_result = es; #1;
            n_tests++; if (add_result_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_add_ack[%0d]: got %b exp 1", t, add_result_ack); end
            tick();
            add_result_ready = 1'b0; #1;
            n_tests++; if (resp_ready !== oh || resp_result !== es) begin n_fail++; $display("FAIL b2b_resp[%0d]: got ready %b result %h", t, resp_ready, resp_result); end
            resp_ack = oh;
            req_stb = req_stb | oh;
            tick();
            resp_ack = 2'b00;
        end
        req_stb = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        req_a = {F_4, F_1};
        req_b = {F_0P5, F_2};
        req_stb = 2'b01;
        tick(); #1;
        n_tests++; if (req_ack !== 2'b01) begin n_fail++; $display("FAIL to_ack: got %b exp 01", req_ack); end
        req_stb = 2'b00;
        repeat (7) tick();
        tick(); #1;
        n_tests++; if (resp_ready !== 2'b00) begin n_fail++; $display("FAIL to_early: got %b exp 00", resp_ready); end
        tick(); #1;
        n_tests++; if (resp_ready !== 2'b01 || resp_err !== 1'b1) begin n_fail++; $display("FAIL to_resp: got ready %b err %b exp 01 1", resp_ready, resp_err); end
        n_tests++; if (resp_result !== ZERO) begin n_fail++; $display("FAIL to_result: got %h exp 0", resp_result); end
        resp_ack = 2'b01;
        req_stb = 2'b10;
        tick();
        resp_ack = 2'b00; #1;
        n_tests++; if (resp_err !== 1'b0 || resp_ready !== 2'b00) begin n_fail++; $display("FAIL to_err_clear: got err %b ready %b exp 0 00", resp_err, resp_ready); end
        tick(); #1;
        n_tests++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL to_stale_block: got %b exp 00", req_ack); end
        add_result_ready = 1'b1; add_result = F_7; #1;
        n_tests++; if (add_result_ack !== 1'b1) begin n_fail++; $display("FAIL to_drain_ack: got %b exp 1", add_result_ack); end
        tick();
        add_result_ready = 1'b0; #1;
        n_tests++; if (req_ack !== 2'b00 || resp_result !== ZERO) begin n_fail++; $display("FAIL to_after_drain: got ack %b result %h", req_ack, resp_result); end
        tick(); #1;
        n_tests++; if (req_ack !== 2'b10 || add_a !== F_4) begin n_fail++; $display("FAIL to_next_grant: got ack %b a %h", req_ack, add_a); end
        req_stb = 2'b00;
        tick();
        add_result_ready = 1'b1; add_result = F_4P5;
        tick();
        add_result_ready = 1'b0; #1;
        n_tests++; if (resp_ready !== 2'b10 || resp_err !== 1'b0 || resp_result !== F_4P5) begin n_fail++; $display("FAIL to_next_resp: got ready %b err %b result %h", resp_ready, resp_err, resp_result); end
        resp_ack = 2'b10;
        tick();
        resp_ack = 2'b00;
    endtask

    task automatic test_reset_mid();
        req_stb = 2'b10;
        tick(); #1;
        n_tests++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL rm_ack: got %b exp 10", req_ack); end
        req_stb = 2'b00;
        tick(); #1;
        reset = 1'b0; #1;
        n_tests++; if (req_ack !== 2'b00 || resp_ready !== 2'b00 || resp_err !== 1'b0) begin n_fail++; $display("FAIL rm_ctrl: got ack %b ready %b err %b", req_ack, resp_ready, resp_err); end
        n_tests++; if (add_a !== ZERO || add_b !== ZERO || resp_result !== ZERO) begin n_fail++; $display("FAIL rm_data: got a %h b %h r %h", add_a, add_b, resp_result); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_tests++; if (resp_ready !== 2'b00) begin n_fail++; $display("FAIL rm_no_resp[%0d]: got %b exp 00", i, resp_ready); end
        end
        req_stb = 2'b11;
        tick(); #1;
        n_tests++; if (req_ack !== 2'b01) begin n_fail++; $display("FAIL rm_first_grant: got %b exp 01", req_ack); end
    endtask

    task automatic test_hold();
        req_stb = 2'b10;
        tick();
        add_result_ready = 1'b1; add_result = F_3;
        tick();
        add_result_ready = 1'b0; #1;
        n_tests++; if (resp_ready !== 2'b01) begin n_fail++; $display("FAIL hold_r0: got %b exp 01", resp_ready); end
        resp_ack = 2'b01;
        tick();
        resp_ack = 2'b00;
        tick(); #1;
        n_tests++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL hold_grant1: got %b exp 10", req_ack); end
        req_stb = 2'b01;
        tick();
        add_result_ready = 1'b1; add_result = F_4P5;
        tick();
        add_result_ready = 1'b0; add_result = F_7;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_tests++; if (resp_ready !== 2'b10) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b exp 10", i, resp_ready); end
            n_tests++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL hold_no_ack[%0d]: got %b exp 00", i, req_ack); end
            n_tests++; if (resp_result !== F_4P5) begin n_fail++; $display("FAIL hold_result[%0d]: got %h", i, resp_result); end
            resp_ack = (i == 5) ? 2'b01 : 2'b00;
            tick();
        end
        resp_ack = 2'b10;
        tick();
        resp_ack = 2'b00; #1;
        n_tests++; if (req_ack !== 2'b00 || resp_ready !== 2'b00) begin n_fail++; $display("FAIL hold_k1: got ack %b ready %b exp 00 00", req_ack, resp_ready); end
        tick(); #1;
        n_tests++; if (req_ack !== 2'b01) begin n_fail++; $display("FAIL hold_k2: got %b exp 01", req_ack); end
        req_stb = 2'b00;
        tick();
        add_result_ready = 1'b1; add_result = F_3;
        tick();
        add_result_ready = 1'b0; #1;
        n_tests++; if (resp_ready !== 2'b01 || resp_result !== F_3) begin n_fail++; $display("FAIL hold_last: got ready %b result %h", resp_ready, resp_result); end
        resp_ack = 2'b01;
        tick();
        resp_ack = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: got no finish exp finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
